// File: rtl/board_uart_tx_pkg.sv
// rtl/board_uart_tx_pkg.sv - frame constants, state encodings and square-to-byte helper for the board link
package board_uart_tx_pkg;

  localparam logic [7:0] SYNC_BYTE   = 8'hA5;
  localparam int         FRAME_BYTES = 67;
  localparam int         SQ_BITS     = 3;
  localparam int         NUM_SQ      = 64;
  localparam int         BOARD_W     = SQ_BITS * NUM_SQ;
  localparam logic [6:0] LAST_BYTE   = 7'(FRAME_BYTES - 1);

  typedef enum logic [1:0] {BIT_IDLE, BIT_START, BIT_DATA, BIT_STOP} bit_state_e;
  typedef enum logic       {FRM_IDLE, FRM_RUN} frm_state_e;

  function automatic logic [7:0] sq_byte(input logic [BOARD_W-1:0] board, input logic [5:0] sq);
    logic [7:0] base;
    base = 8'(sq) * 8'(SQ_BITS);
    return {5'b0, board[base +: SQ_BITS]};
  endfunction

endpackage

// File: rtl/board_uart_tx_if.sv
// rtl/board_uart_tx_if.sv - board-state inputs and UART line outputs between game side and the read-out port
interface board_uart_tx_if;
  import board_uart_tx_pkg::*;

  logic [BOARD_W-1:0] serialized_board;
  logic [7:0]         turn_count;
  logic               dump_req;
  logic               tx;
  logic               busy;
  logic               frame_done;

  modport master (output serialized_board, turn_count, dump_req,
                  input  tx, busy, frame_done);
  modport slave  (input  serialized_board, turn_count, dump_req,
                  output tx, busy, frame_done);

endinterface

// File: rtl/uart_tx_byte.sv
// rtl/uart_tx_byte.sv - 8N1 byte serializer; ready also rises in the last stop-bit cycle so bytes chain gap-free
module uart_tx_byte
  import board_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       ready,
  output logic       tx
);

  localparam int            CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

  bit_state_e    state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          tx_q, tx_d;
  logic          bit_end;

  assign bit_end = (baud_q == BAUD_LAST);
  assign ready   = (state_q == BIT_IDLE) || (state_q == BIT_STOP && bit_end);
  assign tx      = tx_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= BIT_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      BIT_IDLE:  if (start) state_d = BIT_START;
      BIT_START: if (bit_end) state_d = BIT_DATA;
      BIT_DATA:  if (bit_end && bit_q == 3'd7) state_d = BIT_STOP;
      BIT_STOP:  if (bit_end) state_d = start ? BIT_START : BIT_IDLE;
      default:   state_d = BIT_IDLE;
    endcase
  end

  // tx is registered: the level for the next bit is computed one cycle ahead of its first clock
  always_comb begin
    baud_d  = bit_end ? '0 : baud_q + CW'(1);
    bit_d   = bit_q;
    shreg_d = shreg_q;
    tx_d    = tx_q;
    case (state_q)
      BIT_IDLE: begin
        baud_d = '0;
        tx_d   = 1'b1;
        if (start) begin
          shreg_d = data;
          tx_d    = 1'b0;
        end
      end
      BIT_START: if (bit_end) begin
        tx_d  = shreg_q[0];
        bit_d = 3'd0;
      end
      BIT_DATA: if (bit_end) begin
        if (bit_q == 3'd7) begin
          tx_d = 1'b1;
        end else begin
          shreg_d = shreg_q >> 1;
          tx_d    = shreg_q[1];
          bit_d   = bit_q + 3'd1;
        end
      end
      BIT_STOP: if (bit_end) begin
        tx_d = 1'b1;
        if (start) begin
          shreg_d = data;
          tx_d    = 1'b0;
        end
      end
      default: tx_d = 1'b1;
    endcase
  end

endmodule

// File: rtl/board_uart_tx.sv
// rtl/board_uart_tx.sv - snapshots board and turn on a turn change or request and sends them as one UART frame
module board_uart_tx
  import board_uart_tx_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 115200
) (
  input  logic           clk,
  input  logic           rst,
  board_uart_tx_if.slave bus
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;

  frm_state_e         state_q, state_d;
  logic [BOARD_W-1:0] board_q, board_d;
  logic [7:0]         turn_q, turn_d;
  logic [7:0]         last_turn_q, last_turn_d;
  logic [7:0]         csum_q, csum_d;
  logic [6:0]         byte_idx_q, byte_idx_d;
  logic               req_pend_q, req_pend_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [6:0]         byte_sel;
  logic [7:0]         byte_data;
  logic               trigger, start_frame, ser_start, ser_ready, ser_tx;

  assign trigger     = req_pend_q || (bus.turn_count != last_turn_q);
  assign start_frame = (state_q == FRM_IDLE) && trigger;
  // byte_sel is the byte about to be handed to the serializer
  assign byte_sel    = (state_q == FRM_IDLE) ? 7'd0 : byte_idx_q + 7'd1;
  assign ser_start   = start_frame || (state_q == FRM_RUN && ser_ready && byte_idx_q != LAST_BYTE);

  uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_ser (
    .clk   (clk),
    .rst   (rst),
    .start (ser_start),
    .data  (byte_data),
    .ready (ser_ready),
    .tx    (ser_tx)
  );

  assign bus.tx         = ser_tx;
  assign bus.busy       = busy_q;
  assign bus.frame_done = done_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= FRM_IDLE;
      board_q     <= '0;
      turn_q      <= '0;
      last_turn_q <= '0;
      csum_q      <= '0;
      byte_idx_q  <= '0;
      req_pend_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      board_q     <= board_d;
      turn_q      <= turn_d;
      last_turn_q <= last_turn_d;
      csum_q      <= csum_d;
      byte_idx_q  <= byte_idx_d;
      req_pend_q  <= req_pend_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FRM_IDLE: if (trigger) state_d = FRM_RUN;
      FRM_RUN:  if (ser_ready && byte_idx_q == LAST_BYTE) state_d = FRM_IDLE;
      default:  state_d = FRM_IDLE;
    endcase
  end

  always_comb begin
    byte_data = SYNC_BYTE;
    if (byte_sel == 7'd1)
      byte_data = turn_q;
    else if (byte_sel == LAST_BYTE)
      byte_data = csum_q;
    else if (byte_sel >= 7'd2)
      byte_data = sq_byte(board_q, 6'(byte_sel - 7'd2));
  end

  always_comb begin
    board_d     = board_q;
    turn_d      = turn_q;
    last_turn_d = last_turn_q;
    csum_d      = csum_q;
    byte_idx_d  = byte_idx_q;
    req_pend_d  = req_pend_q | bus.dump_req;
    busy_d      = busy_q;
    done_d      = 1'b0;
    if (start_frame) begin
      board_d     = bus.serialized_board;
      turn_d      = bus.turn_count;
      last_turn_d = bus.turn_count;
      req_pend_d  = bus.dump_req;
      csum_d      = '0;
      byte_idx_d  = '0;
      busy_d      = 1'b1;
    end else if (state_q == FRM_RUN && ser_ready) begin
      if (byte_idx_q != LAST_BYTE) begin
        byte_idx_d = byte_idx_q + 7'd1;
        if (byte_sel != LAST_BYTE)
          csum_d = csum_q ^ byte_data;
      end else begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_board_uart_tx.sv
// tb/tb_board_uart_tx.sv - directed checks of framing, triggers, snapshot and reset for board_uart_tx
module tb_board_uart_tx;
  import board_uart_tx_pkg::*;

  localparam int CPB       = 4;
  localparam int FRAME_CYC = 670 * CPB;
  localparam int WAIT_LIM  = 6000;

  logic clk = 1'b0;
  logic rst;
  board_uart_tx_if bus ();

  board_uart_tx #(.CLK_HZ(16), .BAUD(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   busy_cnt = 0;
  int   fd_cnt = 0;
  int   fd_err = 0;
  int   txlow_cnt = 0;
  logic prev_busy = 1'b0;
  int   ferr = 0;
  bit   done = 1'b0;
  logic [7:0] got   [0:FRAME_BYTES-1];
  logic [7:0] exp_f [0:FRAME_BYTES-1];
  logic       line_s [0:FRAME_CYC-1];

  always @(negedge clk) begin
    if (bus.busy === 1'b1) busy_cnt <= busy_cnt + 1;
    if (bus.tx !== 1'b1) txlow_cnt <= txlow_cnt + 1;
    if (bus.frame_done === 1'b1) begin
      fd_cnt <= fd_cnt + 1;
      if (!(prev_busy === 1'b1 && bus.busy === 1'b0)) fd_err <= fd_err + 1;
    end
    prev_busy <= bus.busy;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [BOARD_W-1:0] mk_board(input int seed);
    logic [BOARD_W-1:0] b;
    for (int k = 0; k < NUM_SQ; k++) b[SQ_BITS*k +: SQ_BITS] = 3'(k * seed + seed);
    return b;
  endfunction

  task automatic model(input logic [BOARD_W-1:0] b, input logic [7:0] t);
    logic [7:0] cs;
    exp_f[0] = 8'hA5;
    exp_f[1] = t;
    cs = t;
    for (int k = 0; k < NUM_SQ; k++) begin
      exp_f[k+2] = {5'b0, b[SQ_BITS*k +: SQ_BITS]};
      cs ^= exp_f[k+2];
    end
    exp_f[FRAME_BYTES-1] = cs;
  endtask

  // waits on the negative edge for the first start bit, then samples every cycle of one frame
  task automatic rx_frame(output int lat);
    lat = 0;
    while (bus.tx !== 1'b0 && lat < WAIT_LIM) begin
      @(negedge clk);
      lat++;
    end
    ferr = 0;
    if (bus.tx !== 1'b0) begin
      ferr = 999;
      for (int j = 0; j < FRAME_BYTES; j++) got[j] = 'x;
      return;
    end
    line_s[0] = bus.tx;
    for (int i = 1; i < FRAME_CYC; i++) begin
      @(negedge clk);
      line_s[i] = bus.tx;
    end
    for (int j = 0; j < FRAME_BYTES; j++) begin
      for (int k = 0; k < 10; k++) begin
        logic v;
        v = line_s[(j*10 + k)*CPB + CPB/2];
        if (k == 0) begin
          if (v !== 1'b0) ferr++;
        end else if (k == 9) begin
          if (v !== 1'b1) ferr++;
        end else begin
          got[j][k-1] = v;
        end
      end
    end
  endtask

  task automatic check_frame(input string tag);
    int bad;
    bad = 0;
    for (int j = 0; j < FRAME_BYTES; j++) if (got[j] !== exp_f[j]) bad++;
    chk({tag, "_bytes"}, 32'(bad), 0);
    chk({tag, "_framing"}, 32'(ferr), 0);
  endtask

  initial begin
    int lat;
    int b0;
    int f0;
    int pbad;
    int zbad;
    logic [9:0] pat;
    logic [BOARD_W-1:0] br;

    rst = 1'b0;
    bus.serialized_board = '0;
    bus.turn_count = 8'd0;
    bus.dump_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_tx", 32'(bus.tx), 1);
    chk("reset_busy", 32'(bus.busy), 0);
    chk("reset_frame_done", 32'(bus.frame_done), 0);

    b0 = busy_cnt;
    f0 = txlow_cnt;
    rst = 1'b1;
    repeat (1000) @(negedge clk);
    chk("idle_busy_cycles", 32'(busy_cnt - b0), 0);
    chk("idle_tx_low_cycles", 32'(txlow_cnt - f0), 0);

    bus.serialized_board[2:0] = 3'b101;
    bus.serialized_board[BOARD_W-1 -: 3] = 3'b010;
    b0 = busy_cnt;
    f0 = fd_cnt;
    bus.turn_count = 8'd1;
    rx_frame(lat);
    chk("t2_start_latency", 32'(lat), 1);
    pat = 10'b1101001010;
    pbad = 0;
    for (int i = 0; i < 10*CPB; i++) if (line_s[i] !== pat[i/CPB]) pbad++;
    chk("t2_sync_bit_periods", 32'(pbad), 0);
    chk("t2_byte0_sync", 32'(got[0]), 32'h A5);
    chk("t2_byte1_turn", 32'(got[1]), 32'h01);
    chk("t2_byte2_sq0", 32'(got[2]), 32'h05);
    chk("t2_byte65_sq63", 32'(got[65]), 32'h02);
    chk("t2_byte66_csum", 32'(got[66]), 32'h06);
    zbad = 0;
    for (int j = 3; j < 65; j++) if (got[j] !== 8'h00) zbad++;
    chk("t2_empty_squares", 32'(zbad), 0);
    chk("t2_framing", 32'(ferr), 0);
    repeat (5) @(negedge clk);
    chk("t2_busy_cycles", 32'(busy_cnt - b0), 2680);
    chk("t2_frame_done_pulses", 32'(fd_cnt - f0), 1);

    f0 = fd_cnt;
    bus.serialized_board = mk_board(1);
    bus.dump_req = 1'b1;
    fork
      rx_frame(lat);
      begin
        @(negedge clk);
        bus.dump_req = 1'b0;
        repeat (200) @(negedge clk);
        for (int p = 0; p < 3; p++) begin
          bus.dump_req = 1'b1;
          @(negedge clk);
          bus.dump_req = 1'b0;
          repeat (150) @(negedge clk);
        end
        bus.turn_count = 8'd2;
        bus.serialized_board = mk_board(3);
      end
    join
    chk("t3_req_latency", 32'(lat), 2);
    model(mk_board(1), 8'd1);
    check_frame("t3_first");
    rx_frame(lat);
    chk("t3_followup_gap", 32'(lat), 2);
    model(mk_board(3), 8'd2);
    check_frame("t3_followup");
    repeat (5) @(negedge clk);
    b0 = busy_cnt;
    repeat (200) @(negedge clk);
    chk("t3_no_third_frame", 32'(busy_cnt - b0), 0);
    chk("t3_frame_done_pulses", 32'(fd_cnt - f0), 2);

    bus.turn_count = 8'd3;
    bus.dump_req = 1'b1;
    bus.serialized_board = mk_board(5);
    done = 1'b0;
    fork
      begin
        rx_frame(lat);
        done = 1'b1;
      end
      begin
        int c;
        c = 0;
        @(negedge clk);
        bus.dump_req = 1'b0;
        while (!done) begin
          bus.serialized_board = c[0] ? mk_board(5) : ~mk_board(5);
          c++;
          @(negedge clk);
        end
        bus.serialized_board = mk_board(7);
      end
    join
    chk("t4_turn_latency", 32'(lat), 1);
    model(mk_board(5), 8'd3);
    check_frame("t4_toggled");
    rx_frame(lat);
    chk("t4_pending_req_found", 32'(lat < WAIT_LIM), 1);
    model(mk_board(7), 8'd3);
    check_frame("t4_pending_req");

    repeat (5) @(negedge clk);
    br = mk_board(2);
    bus.serialized_board = br;
    bus.turn_count = 8'd4;
    lat = 0;
    while (bus.tx !== 1'b0 && lat < WAIT_LIM) begin
      @(negedge clk);
      lat++;
    end
    chk("t5_start_latency", 32'(lat), 1);
    repeat (500) @(negedge clk);
    chk("t5_tx_low_before_reset", 32'(bus.tx), 0);
    #2 rst = 1'b0;
    #1;
    chk("t5_tx_async_reset", 32'(bus.tx), 1);
    chk("t5_busy_async_reset", 32'(bus.busy), 0);
    bus.turn_count = 8'd5;
    repeat (3) @(negedge clk);
    chk("t5_idle_in_reset", 32'(bus.busy), 0);
    rst = 1'b1;
    rx_frame(lat);
    chk("t5_restart_latency", 32'(lat), 1);
    chk("t5_byte1_turn", 32'(got[1]), 32'h05);
    model(br, 8'd5);
    check_frame("t5_after_reset");
    repeat (5) @(negedge clk);
    chk("frame_done_with_busy_fall", 32'(fd_err), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
